// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole sequencer.
package mole_pkg;

  // Game sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    GAP,
    DRAW,
    LOAD,
    UP,
    MISS,
    OVER
  } moleState;

  localparam int SCORE_W = 8;
  localparam int MISS_W  = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

  // Countdown width; wide enough for MIN_UP_TICKS + 2**UP_RANGE_W - 1 and GAP_TICKS.
  localparam int CNT_W = 16;

  // Score increment that sticks at SCORE_MAX instead of wrapping.
  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tick_countdown.sv
// Loadable down-counter stepped by the 1 ms tick; shared by the gap and up windows.
module tick_countdown
  import mole_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] count;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero   = (count == '0);
  assign expire = tick && (count == W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: draws moles from the PRBS, times gap/up windows,
// judges hits and misses, and keeps score.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int NUM_MOLES    = 8,
  parameter int MIN_UP_TICKS = 200,
  parameter int UP_RANGE_W   = 8,
  parameter int GAP_TICKS    = 100,
  parameter int MAX_MISSES   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit_btn,
  input  logic [15:0]          prbs_seq,
  output logic                 prbs_shift,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [SCORE_W-1:0]   score,
  output logic [MISS_W-1:0]    misses,
  output logic                 game_over,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_MOLES);

  moleState             state;
  logic [NUM_MOLES-1:0] hitBtnQ;
  logic [NUM_MOLES-1:0] hitEdge;
  // Index of the last drawn mole; during UP it is also the lit mole.
  logic [IDX_W-1:0]     prevIdx;
  logic [IDX_W-1:0]     rawIdx;
  logic [IDX_W-1:0]     drawIdx;
  logic [CNT_W-1:0]     upTicks;
  logic [MISS_W-1:0]    missesNext;
  logic                 hitNow;

  logic                 cntLoad;
  logic [CNT_W-1:0]     cntLoadValue;
  logic                 cntTick;
  logic                 cntZero;
  logic                 cntExpire;

  // Middle PRBS bits are not used for index or duration.
  logic                 unusedPrbs;
  assign unusedPrbs = ^prbs_seq;

  // Button history for rising-edge detection, kept in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitBtnQ <= '0;
    end else begin
      hitBtnQ <= hit_btn;
    end
  end

  assign hitEdge    = hit_btn & ~hitBtnQ;
  assign hitNow     = hitEdge[prevIdx];
  assign missesNext = misses + 1'b1;

  // Draw the next mole from the freshly shifted PRBS; never repeat the previous hole.
  always_comb begin
    rawIdx  = prbs_seq[IDX_W-1:0];
    drawIdx = rawIdx;
    if (rawIdx == prevIdx) begin
      drawIdx = rawIdx + 1'b1;  // NUM_MOLES is a power of two, so this wraps
    end
    upTicks = CNT_W'(MIN_UP_TICKS) + CNT_W'(prbs_seq[15 -: UP_RANGE_W]);
  end

  // Countdown reloads: gap length on game start/hit/non-final miss, up window in LOAD.
  always_comb begin
    cntLoad      = 1'b0;
    cntLoadValue = CNT_W'(GAP_TICKS);
    case (state)
      IDLE, OVER: cntLoad = start;
      LOAD: begin
        cntLoad      = 1'b1;
        cntLoadValue = upTicks;
      end
      UP:   cntLoad = hitNow;
      MISS: cntLoad = (missesNext != MISS_W'(MAX_MISSES));
      default: cntLoad = 1'b0;
    endcase
  end

  // Ticks only matter while a window is being timed.
  assign cntTick = tick && ((state == GAP) || (state == UP));

  tick_countdown #(
    .W(CNT_W)
  ) countdown (
    .clk      (clk),
    .rst      (rst),
    .tick     (cntTick),
    .load     (cntLoad),
    .loadValue(cntLoadValue),
    .zero     (cntZero),
    .expire   (cntExpire)
  );

  // Game sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prbs_shift  <= 1'b0;
      mole_onehot <= '0;
      score       <= '0;
      misses      <= '0;
      game_over   <= 1'b0;
      busy        <= 1'b0;
      prevIdx     <= '0;
    end else begin
      prbs_shift <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
            busy      <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (cntZero || cntExpire) begin
            prbs_shift <= 1'b1;
            state      <= DRAW;
          end
        end
        DRAW: begin
          state <= LOAD;
        end
        LOAD: begin
          prevIdx     <= drawIdx;
          mole_onehot <= NUM_MOLES'(1) << drawIdx;
          state       <= UP;
        end
        UP: begin
          if (hitNow) begin
            score       <= satInc(score);
            mole_onehot <= '0;
            state       <= GAP;
          end else if (cntExpire || cntZero) begin
            // A zero count can only arise from a zero-length window; treat it as expired.
            mole_onehot <= '0;
            state       <= MISS;
          end
        end
        MISS: begin
          misses <= missesNext;
          if (missesNext == MISS_W'(MAX_MISSES)) begin
            game_over <= 1'b1;
            busy      <= 1'b0;
            state     <= OVER;
          end else begin
            state <= GAP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
